// File: rtl/hilo_muldiv.sv
// hilo_muldiv -- iterative multiply/divide unit holding the HI/LO register pair.
//
// Purpose:
//   Runs MULTU/MULT (shift-add) and DIVU/DIV (restoring division) in 32
//   iterations, then applies sign correction and loads HI/LO. HI/LO can also
//   be written directly (MTHI/MTLO) while the unit is idle. HI/LO keep their
//   previous values until the final adjust step; all partial results live in
//   private working registers.
//
// Ports:
//   clock      : sole clock, rising edge
//   reset      : asynchronous active-high reset
//   Start      : begin an operation (ignored while Busy)
//   Op         : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled with Start)
//   OperandA   : rs value (multiplicand / dividend)
//   OperandB   : rt value (multiplier / divisor)
//   HiWrite    : MTHI strobe (idle, no Start)
//   LoWrite    : MTLO strobe (idle, no Start)
//   WriteData  : MTHI/MTLO data
//   Hi, Lo     : architectural HI/LO, registered
//   Busy       : high while an operation is in flight
//   Done       : one-cycle completion pulse
module hilo_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   input  logic             HiWrite,
   input  logic             LoWrite,
   input  logic [WIDTH-1:0] WriteData,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             Done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, ADJUST} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             neg_lo_q, neg_lo_d;     // negate quotient / full product
   logic             neg_hi_q, neg_hi_d;     // negate remainder
   logic             div_zero_q, div_zero_d;
   logic [WIDTH-1:0] work_hi_q, work_hi_d;   // partial product high / remainder
   logic [WIDTH-1:0] work_lo_q, work_lo_d;   // multiplier bits / dividend->quotient
   logic [WIDTH-1:0] work_b_q, work_b_d;     // multiplicand / divisor
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Operand magnitudes for the signed ops
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;

   assign a_neg = Op[0] & OperandA[WIDTH-1];
   assign b_neg = Op[0] & OperandB[WIDTH-1];
   assign a_abs = a_neg ? -OperandA : OperandA;
   assign b_abs = b_neg ? -OperandB : OperandB;

   // Shift-add step: add multiplicand when the current multiplier bit is set,
   // then shift the {hi, lo} pair right by one (carry enters the top).
   logic [WIDTH:0] mul_sum;
   assign mul_sum = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, work_b_q} : '0);

   // Restoring step: shift next dividend bit into the remainder and try to
   // subtract. A clear top bit of the difference means "fits". A zero divisor
   // always fits, which shifts the whole dividend into the remainder and sets
   // every quotient bit.
   logic [WIDTH:0]   div_shift, div_diff;
   logic             q_bit;
   logic [WIDTH-1:0] rem_next;

   assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, work_b_q};
   assign q_bit     = div_zero_q | ~div_diff[WIDTH];
   assign rem_next  = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

   logic [2*WIDTH-1:0] prod, prod_neg;
   assign prod     = {work_hi_q, work_lo_q};
   assign prod_neg = -prod;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
      div_zero_d = div_zero_q;
      work_hi_d  = work_hi_q;
      work_lo_d  = work_lo_q;
      work_b_d   = work_b_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (Start) begin
               // Start takes priority over MTHI/MTLO in the same cycle
               is_div_d   = Op[1];
               neg_lo_d   = a_neg ^ b_neg;
               neg_hi_d   = Op[1] ? a_neg : (a_neg ^ b_neg);
               div_zero_d = Op[1] && (OperandB == '0);
               work_hi_d  = '0;
               work_lo_d  = Op[1] ? a_abs : b_abs;
               work_b_d   = Op[1] ? b_abs : a_abs;
               cnt_d      = '0;
               busy_d     = 1'b1;
               state_d    = CALC;
            end else begin
               if (HiWrite) hi_d = WriteData;
               if (LoWrite) lo_d = WriteData;
            end
         end

         CALC: begin
            if (is_div_q) begin
               work_hi_d = rem_next;
               work_lo_d = {work_lo_q[WIDTH-2:0], q_bit};
            end else begin
               work_hi_d = mul_sum[WIDTH:1];
               work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = ADJUST;
         end

         ADJUST: begin
            if (is_div_q) begin
               // The remainder carries the dividend sign, so with a zero
               // divisor it reconstructs OperandA exactly.
               lo_d = div_zero_q ? '1 : (neg_lo_q ? -work_lo_q : work_lo_q);
               hi_d = neg_hi_q ? -work_hi_q : work_hi_q;
            end else begin
               {hi_d, lo_d} = neg_lo_q ? prod_neg : prod;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         div_zero_q <= 1'b0;
         work_hi_q  <= '0;
         work_lo_q  <= '0;
         work_b_q   <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         div_zero_q <= div_zero_d;
         work_hi_q  <= work_hi_d;
         work_lo_q  <= work_lo_d;
         work_b_q   <= work_b_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign Hi   = hi_q;
   assign Lo   = lo_q;
   assign Busy = busy_q;
   assign Done = done_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv -- self-checking bench for hilo_muldiv.
//
// Directed cases for the documented corner results, then randomized
// operations (with biased operands) compared against an arithmetic model of
// HI/LO. Every operation also checks timing: Busy on at the Start edge, Done
// at the 33rd edge after it, Busy high for 33 cycles, HI/LO untouched until
// Done. Operations are issued back to back, so each Start lands on the edge
// where the previous Done is high.
module tb_hilo_muldiv;

   logic        clock = 1'b0;
   logic        reset;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] OperandA, OperandB;
   logic        HiWrite, LoWrite;
   logic [31:0] WriteData;
   logic [31:0] Hi, Lo;
   logic        Busy, Done;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_hi, model_lo;

   always #5 clock = ~clock;

   hilo_muldiv #(.WIDTH(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .Start     (Start),
      .Op        (Op),
      .OperandA  (OperandA),
      .OperandB  (OperandB),
      .HiWrite   (HiWrite),
      .LoWrite   (LoWrite),
      .WriteData (WriteData),
      .Hi        (Hi),
      .Lo        (Lo),
      .Busy      (Busy),
      .Done      (Done)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference result {hi, lo} from plain arithmetic
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: return {32'b0, a} * {32'b0, b};
         2'b01: return sa * sb;
         2'b10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   // Issue one operation. strobe_at_start raises MTHI/MTLO with Start;
   // inject_edge > 0 raises Start/HiWrite/LoWrite so they are sampled at that
   // edge of the running operation.
   task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit strobe_at_start, input int inject_edge);
      logic [63:0] exp;
      logic [31:0] hold_hi, hold_lo;
      int busy_cycles, done_edge;
      bit hold_ok;
      exp     = ref_result(op, a, b);
      hold_hi = model_hi;
      hold_lo = model_lo;
      @(negedge clock);
      Start = 1'b1; Op = op; OperandA = a; OperandB = b;
      if (strobe_at_start) begin
         HiWrite = 1'b1; LoWrite = 1'b1; WriteData = $urandom;
      end
      @(posedge clock); #1;
      Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
      // Operands are only meaningful at the Start edge
      OperandA = $urandom; OperandB = $urandom; Op = 2'($urandom);
      check({name, "_busy_at_e0"}, 64'(Busy), 64'd1);
      check({name, "_done_low_at_e0"}, 64'(Done), 64'd0);
      busy_cycles = 1;
      done_edge   = -1;
      hold_ok     = (Hi === hold_hi) && (Lo === hold_lo);
      for (int e = 1; e <= 40 && done_edge < 0; e++) begin
         if (e == inject_edge) begin
            Start = 1'b1; HiWrite = 1'b1; LoWrite = 1'b1;
            WriteData = 32'hDEAD_BEEF; Op = 2'b10;
         end
         @(posedge clock); #1;
         Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
         if (Done) done_edge = e;
         else if (Hi !== hold_hi || Lo !== hold_lo) hold_ok = 1'b0;
         if (Busy) busy_cycles++;
      end
      check({name, "_done_edge"}, 64'(done_edge), 64'd33);
      check({name, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
      check({name, "_hilo_held"}, 64'(hold_ok), 64'd1);
      check({name, "_hi"}, 64'(Hi), 64'(exp[63:32]));
      check({name, "_lo"}, 64'(Lo), 64'(exp[31:0]));
      model_hi = exp[63:32];
      model_lo = exp[31:0];
      $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h (exp %h %h)",
               name, op, a, b, Hi, Lo, exp[63:32], exp[31:0]);
   endtask

   task automatic mt_write(input bit hw, input bit lw, input logic [31:0] data);
      @(negedge clock);
      HiWrite = hw; LoWrite = lw; WriteData = data;
      @(posedge clock); #1;
      HiWrite = 1'b0; LoWrite = 1'b0;
      if (hw) model_hi = data;
      if (lw) model_lo = data;
      check("mt_hi", 64'(Hi), 64'(model_hi));
      check("mt_lo", 64'(Lo), 64'(model_lo));
      $display("mt hw=%0d lw=%0d data=%h -> hi=%h lo=%h", hw, lw, data, Hi, Lo);
   endtask

   initial begin
      int done_seen;
      logic [31:0] ra, rb;
      reset = 1'b1; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
      HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
      model_hi = '0; model_lo = '0;
      #1;
      check("reset_hi", 64'(Hi), 64'd0);
      check("reset_lo", 64'(Lo), 64'd0);
      check("reset_busy", 64'(Busy), 64'd0);
      check("reset_done", 64'(Done), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      do_op("divu_20_8", 2'b10, 32'd20, 32'd8, 1'b0, 0);
      check("divu_20_8_lo_const", 64'(Lo), 64'd2);
      check("divu_20_8_hi_const", 64'(Hi), 64'd4);
      do_op("mult_m2_3", 2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
      check("mult_m2_3_const", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFFA);
      do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
      check("multu_max_const", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFE_0000_0001);
      do_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
      check("div_m7_2_const", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
      check("div_min_m1_const", {32'(Hi), 32'(Lo)}, 64'h0000_0000_8000_0000);
      do_op("divu_by0", 2'b10, 32'h1234, 32'd0, 1'b0, 0);
      check("divu_by0_const", {32'(Hi), 32'(Lo)}, 64'h0000_1234_FFFF_FFFF);
      do_op("div_neg_by0", 2'b11, 32'h8000_0001, 32'd0, 1'b0, 0);

      // MTHI, then a MULTU disturbed at E10 by Start + strobes
      mt_write(1'b1, 1'b0, 32'hAAAA_5555);
      do_op("multu_2_2_inject", 2'b00, 32'd2, 32'd2, 1'b0, 10);
      check("inject_const", {32'(Hi), 32'(Lo)}, 64'h0000_0000_0000_0004);
      @(posedge clock); #1;
      check("inject_no_second_op", 64'(Busy), 64'd0);

      // Reset mid-way through a DIVU
      @(negedge clock);
      Start = 1'b1; Op = 2'b10; OperandA = 32'd1000; OperandB = 32'd7;
      @(posedge clock); #1;
      Start = 1'b0;
      repeat (15) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("midrst_hi", 64'(Hi), 64'd0);
      check("midrst_lo", 64'(Lo), 64'd0);
      check("midrst_busy", 64'(Busy), 64'd0);
      #1;
      reset = 1'b0;
      model_hi = '0; model_lo = '0;
      done_seen = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (Done) done_seen++;
      end
      check("midrst_no_done", 64'(done_seen), 64'd0);
      do_op("after_reset", 2'b10, 32'd100, 32'd9, 1'b0, 0);

      // Randomized operations with biased operands
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 7))
            0: ra = 32'h8000_0000;
            1: ra = 32'($urandom_range(0, 50));
            2: ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 20));
            2: rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0)
            mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         do_op($sformatf("rnd%0d", i), 2'($urandom), ra, rb,
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 32)) : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
